// File: rtl/fpnew_pkg.sv
// Shared FPU types for the result-side logic.
// Status flags follow the IEEE order {NV,DZ,OF,UF,NX}.
package fpnew_pkg;

  localparam int unsigned FFLAGS_W = 5;

  typedef struct packed {
    logic NV;
    logic DZ;
    logic OF;
    logic UF;
    logic NX;
  } status_t;

endpackage

// File: rtl/fpnew_result_fifo.sv
// In-order FIFO with flush, full/empty and occupancy.
// Storage is registered; the head is driven to 0 when empty.
module fpnew_result_fifo #(
  parameter int unsigned DataW = 38,
  parameter int unsigned Depth = 4
) (
  input  logic                       clk_i,
  input  logic                       rst_i,
  input  logic                       flush_i,
  input  logic                       push_i,
  input  logic                       pop_i,
  input  logic [DataW-1:0]           data_i,
  output logic [DataW-1:0]           data_o,
  output logic                       full_o,
  output logic                       empty_o,
  output logic [$clog2(Depth+1)-1:0] count_o
);

  localparam int unsigned PtrW = $clog2(Depth);
  localparam int unsigned CntW = $clog2(Depth+1);

  logic [DataW-1:0] r_mem [Depth];
  logic [PtrW-1:0]  r_wptr;
  logic [PtrW-1:0]  r_rptr;
  logic [CntW-1:0]  r_count;
  logic             w_push;
  logic             w_pop;

  assign full_o  = (r_count == CntW'(Depth));
  assign empty_o = (r_count == '0);
  assign count_o = r_count;
  assign data_o  = empty_o ? '0 : r_mem[r_rptr];

  // Flush wins over any concurrent push or pop.
  assign w_push = push_i && !full_o && !flush_i;
  assign w_pop  = pop_i && !empty_o && !flush_i;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else if (flush_i) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else begin
      if (w_push) r_wptr <= r_wptr + PtrW'(1);
      if (w_pop)  r_rptr <= r_rptr + PtrW'(1);
      if (w_push && !w_pop)
        r_count <= r_count + CntW'(1);
      else if (w_pop && !w_push)
        r_count <= r_count - CntW'(1);
    end
  end

  always_ff @(posedge clk_i) begin
    if (w_push) r_mem[r_wptr] <= data_i;
  end

endmodule

// File: rtl/fpnew_result_buffer.sv
// FPU result buffer: FIFO toward writeback plus the sticky
// fflags accumulator, updated on retire and by CSR access.
module fpnew_result_buffer
  import fpnew_pkg::*;
#(
  parameter int unsigned Width = 32,
  parameter int unsigned Depth = 4
) (
  input  logic                       clk_i,
  input  logic                       rst_i,
  input  logic                       flush_i,
  input  logic                       in_valid_i,
  output logic                       in_ready_o,
  input  logic [Width-1:0]           result_i,
  input  status_t                    status_i,
  input  logic                       tag_i,
  output logic                       out_valid_o,
  input  logic                       out_ready_i,
  output logic [Width-1:0]           result_o,
  output status_t                    status_o,
  output logic                       tag_o,
  output logic [FFLAGS_W-1:0]        fflags_o,
  input  logic                       fflags_wr_i,
  input  logic [FFLAGS_W-1:0]        fflags_wdata_i,
  input  logic                       fflags_clr_i,
  output logic [$clog2(Depth+1)-1:0] count_o,
  output logic                       busy_o
);

  localparam int unsigned DataW = Width + FFLAGS_W + 1;

  if (Depth < 2 || (Depth & (Depth - 1)) != 0) begin : g_chk
    $error("fpnew_result_buffer: Depth must be a power of two >= 2");
  end

  logic                w_full;
  logic                w_empty;
  logic                w_push;
  logic                w_pop;
  logic [DataW-1:0]    w_wdata;
  logic [DataW-1:0]    w_rdata;
  logic [FFLAGS_W-1:0] w_fflags_base;
  logic [FFLAGS_W-1:0] w_fflags_next;
  logic [FFLAGS_W-1:0] r_fflags;

  assign in_ready_o  = !w_full;
  assign out_valid_o = !w_empty;
  assign busy_o      = !w_empty;
  assign w_push = in_valid_i && in_ready_o && !flush_i;
  assign w_pop  = out_valid_o && out_ready_i && !flush_i;
  assign w_wdata = {result_i, status_i, tag_i};

  fpnew_result_fifo #(
    .DataW (DataW),
    .Depth (Depth)
  ) u_fifo (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .flush_i (flush_i),
    .push_i  (w_push),
    .pop_i   (w_pop),
    .data_i  (w_wdata),
    .data_o  (w_rdata),
    .full_o  (w_full),
    .empty_o (w_empty),
    .count_o (count_o)
  );

  assign result_o = w_rdata[DataW-1 -: Width];
  assign status_o = status_t'(w_rdata[FFLAGS_W:1]);
  assign tag_o    = w_rdata[0];
  assign fflags_o = r_fflags;

  // A CSR write never hides the exceptions of a beat retiring now.
  always_comb begin
    w_fflags_base = r_fflags;
    if (fflags_wr_i)
      w_fflags_base = fflags_wdata_i;
    else if (fflags_clr_i)
      w_fflags_base = '0;
    w_fflags_next = w_fflags_base;
    if (w_pop)
      w_fflags_next = w_fflags_base | FFLAGS_W'(status_o);
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) r_fflags <= '0;
    else       r_fflags <= w_fflags_next;
  end

endmodule

// File: tb/tb_fpnew_result_buffer.sv
// Directed bench for fpnew_result_buffer (Width=32, Depth=4).
// Inputs change 1ns after a rising edge; outputs checked there.
module tb_fpnew_result_buffer;
  import fpnew_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic        flush;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] result_in;
  status_t     status_in;
  logic        tag_in;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] result_out;
  status_t     status_out;
  logic        tag_out;
  logic [4:0]  fflags;
  logic        fl_wr;
  logic [4:0]  fl_wdata;
  logic        fl_clr;
  logic [2:0]  count;
  logic        busy;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  fpnew_result_buffer #(.Width(32), .Depth(4)) dut (
    .clk_i          (clk),
    .rst_i          (rst),
    .flush_i        (flush),
    .in_valid_i     (in_valid),
    .in_ready_o     (in_ready),
    .result_i       (result_in),
    .status_i       (status_in),
    .tag_i          (tag_in),
    .out_valid_o    (out_valid),
    .out_ready_i    (out_ready),
    .result_o       (result_out),
    .status_o       (status_out),
    .tag_o          (tag_out),
    .fflags_o       (fflags),
    .fflags_wr_i    (fl_wr),
    .fflags_wdata_i (fl_wdata),
    .fflags_clr_i   (fl_clr),
    .count_o        (count),
    .busy_o         (busy)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [31:0] r,
                       input logic [4:0] s, input logic t);
    in_valid  = v;
    result_in = r;
    status_in = s;
    tag_in    = t;
  endtask

  task automatic test_reset();
    rst = 1'b1; flush = 1'b0; out_ready = 1'b0;
    fl_wr = 1'b0; fl_wdata = '0; fl_clr = 1'b0;
    drive(1'b0, '0, '0, 1'b0);
    tick(); tick();
    rst = 1'b0;
    tick();
    n_cmp++; if (in_ready !== 1'b1) begin n_err++;
      $display("FAIL rst_in_ready got %b want 1", in_ready); end
    n_cmp++; if (out_valid !== 1'b0) begin n_err++;
      $display("FAIL rst_out_valid got %b want 0", out_valid); end
    n_cmp++; if (result_out !== 32'h0) begin n_err++;
      $display("FAIL rst_result got %h want 0", result_out); end
    n_cmp++; if (status_out !== 5'h0) begin n_err++;
      $display("FAIL rst_status got %h want 0", status_out); end
    n_cmp++; if (tag_out !== 1'b0) begin n_err++;
      $display("FAIL rst_tag got %b want 0", tag_out); end
    n_cmp++; if (fflags !== 5'h0) begin n_err++;
      $display("FAIL rst_fflags got %h want 0", fflags); end
    n_cmp++; if (count !== 3'd0) begin n_err++;
      $display("FAIL rst_count got %0d want 0", count); end
    n_cmp++; if (busy !== 1'b0) begin n_err++;
      $display("FAIL rst_busy got %b want 0", busy); end
  endtask

  task automatic test_order();
    logic [31:0] exp_r [3];
    logic        exp_t [3];
    exp_r[0] = 32'h3F800000; exp_t[0] = 1'b0;
    exp_r[1] = 32'h40000000; exp_t[1] = 1'b1;
    exp_r[2] = 32'h40400000; exp_t[2] = 1'b0;
    out_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, exp_r[i], 5'h0, exp_t[i]);
      tick();
      n_cmp++; if (out_valid !== 1'b1) begin n_err++;
        $display("FAIL order_latency beat %0d got %b want 1",
                 i, out_valid); end
    end
    drive(1'b0, '0, '0, 1'b0);
    n_cmp++; if (count !== 3'd3) begin n_err++;
      $display("FAIL order_count got %0d want 3", count); end
    n_cmp++; if (in_ready !== 1'b1) begin n_err++;
      $display("FAIL order_in_ready got %b want 1", in_ready); end
    out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      n_cmp++;
      if (out_valid !== 1'b1 || result_out !== exp_r[i] ||
          tag_out !== exp_t[i]) begin
        n_err++;
        $display("FAIL order_head %0d got v%b %h t%b want v1 %h t%b",
                 i, out_valid, result_out, tag_out,
                 exp_r[i], exp_t[i]);
      end
      tick();
    end
    out_ready = 1'b0;
    n_cmp++; if (out_valid !== 1'b0 || busy !== 1'b0) begin n_err++;
      $display("FAIL order_drained got v%b b%b want 0 0",
               out_valid, busy); end
  endtask

  task automatic test_full();
    logic [31:0] exp_r [4];
    exp_r[0] = 32'h101; exp_r[1] = 32'h102;
    exp_r[2] = 32'h103; exp_r[3] = 32'h999;
    out_ready = 1'b0;
    drive(1'b1, 32'h100, 5'h0, 1'b0); tick();
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, exp_r[i], 5'h0, 1'b1); tick();
    end
    n_cmp++; if (in_ready !== 1'b0 || count !== 3'd4) begin n_err++;
      $display("FAIL full_state got rdy%b cnt%0d want rdy0 cnt4",
               in_ready, count); end
    drive(1'b1, 32'h999, 5'h0, 1'b1);
    tick();
    n_cmp++; if (count !== 3'd4 || result_out !== 32'h100) begin
      n_err++;
      $display("FAIL full_holdoff got cnt%0d %h want cnt4 100",
               count, result_out); end
    out_ready = 1'b1;
    tick();
    n_cmp++; if (count !== 3'd3 || in_ready !== 1'b1) begin n_err++;
      $display("FAIL full_no_passthru got cnt%0d rdy%b want 3 1",
               count, in_ready); end
    out_ready = 1'b0;
    tick();
    drive(1'b0, '0, '0, 1'b0);
    n_cmp++; if (count !== 3'd4) begin n_err++;
      $display("FAIL full_late_push got cnt%0d want 4", count); end
    out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      n_cmp++; if (result_out !== exp_r[i]) begin n_err++;
        $display("FAIL full_drain %0d got %h want %h",
                 i, result_out, exp_r[i]); end
      tick();
    end
    out_ready = 1'b0;
    n_cmp++; if (count !== 3'd0) begin n_err++;
      $display("FAIL full_empty got cnt%0d want 0", count); end
  endtask

  task automatic test_back_to_back();
    out_ready = 1'b0;
    drive(1'b1, 32'h1000, 5'h0, 1'b0);
    tick();
    out_ready = 1'b1;
    for (int i = 1; i <= 20; i++) begin
      drive(1'b1, 32'h1000 + 32'(i), 5'h0, i[0]);
      n_cmp++;
      if (count !== 3'd1 || result_out !== 32'h1000 + 32'(i - 1)) begin
        n_err++;
        $display("FAIL b2b beat %0d got cnt%0d %h want cnt1 %h",
                 i, count, result_out, 32'h1000 + 32'(i - 1));
      end
      tick();
    end
    drive(1'b0, '0, '0, 1'b0);
    n_cmp++; if (result_out !== 32'h1014 || tag_out !== 1'b0) begin
      n_err++;
      $display("FAIL b2b_last got %h t%b want 1014 t0",
               result_out, tag_out); end
    tick();
    out_ready = 1'b0;
    n_cmp++; if (count !== 3'd0) begin n_err++;
      $display("FAIL b2b_empty got cnt%0d want 0", count); end
  endtask

  task automatic test_flags();
    out_ready = 1'b0;
    drive(1'b1, 32'h1, 5'h01, 1'b0); tick();
    drive(1'b1, 32'h2, 5'h10, 1'b0); tick();
    drive(1'b0, '0, '0, 1'b0);
    n_cmp++; if (fflags !== 5'h00) begin n_err++;
      $display("FAIL flags_on_push got %h want 00", fflags); end
    out_ready = 1'b1;
    tick();
    n_cmp++; if (fflags !== 5'h01) begin n_err++;
      $display("FAIL flags_nx got %h want 01", fflags); end
    tick();
    out_ready = 1'b0;
    n_cmp++; if (fflags !== 5'h11) begin n_err++;
      $display("FAIL flags_nv_nx got %h want 11", fflags); end
    fl_clr = 1'b1; tick(); fl_clr = 1'b0;
    n_cmp++; if (fflags !== 5'h00) begin n_err++;
      $display("FAIL flags_clr got %h want 00", fflags); end
    drive(1'b1, 32'h3, 5'h01, 1'b0); tick();
    drive(1'b0, '0, '0, 1'b0);
    out_ready = 1'b1; fl_wr = 1'b1; fl_wdata = 5'h04;
    tick();
    out_ready = 1'b0; fl_wr = 1'b0; fl_wdata = '0;
    n_cmp++; if (fflags !== 5'h05) begin n_err++;
      $display("FAIL flags_wr_pop got %h want 05", fflags); end
  endtask

  task automatic test_flush();
    out_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, 32'h200 + 32'(i), 5'h02, 1'b0); tick();
    end
    n_cmp++; if (count !== 3'd3) begin n_err++;
      $display("FAIL flush_pre got cnt%0d want 3", count); end
    flush = 1'b1; out_ready = 1'b1;
    drive(1'b1, 32'h2FF, 5'h08, 1'b1);
    tick();
    flush = 1'b0; out_ready = 1'b0;
    drive(1'b0, '0, '0, 1'b0);
    n_cmp++;
    if (count !== 3'd0 || out_valid !== 1'b0 ||
        fflags !== 5'h05 || result_out !== 32'h0) begin
      n_err++;
      $display("FAIL flush_state got cnt%0d v%b fl%h %h want 0 0 05 0",
               count, out_valid, fflags, result_out);
    end
    drive(1'b1, 32'hABC, 5'h08, 1'b1); tick();
    drive(1'b0, '0, '0, 1'b0);
    n_cmp++;
    if (out_valid !== 1'b1 || result_out !== 32'hABC ||
        tag_out !== 1'b1 || count !== 3'd1) begin
      n_err++;
      $display("FAIL flush_repush got v%b %h t%b cnt%0d want 1 abc 1 1",
               out_valid, result_out, tag_out, count);
    end
    out_ready = 1'b1; tick(); out_ready = 1'b0;
    n_cmp++; if (fflags !== 5'h0D) begin n_err++;
      $display("FAIL flush_after_pop got %h want 0d", fflags); end
  endtask

  task automatic test_async_reset();
    out_ready = 1'b0;
    fl_wr = 1'b1; fl_wdata = 5'h1F;
    drive(1'b1, 32'h301, 5'h01, 1'b1); tick();
    fl_wr = 1'b0; fl_wdata = '0;
    drive(1'b1, 32'h302, 5'h02, 1'b0); tick();
    drive(1'b0, '0, '0, 1'b0);
    n_cmp++; if (count !== 3'd2 || fflags !== 5'h1F) begin n_err++;
      $display("FAIL arst_pre got cnt%0d fl%h want 2 1f",
               count, fflags); end
    #2 rst = 1'b1;
    #1;
    n_cmp++;
    if (count !== 3'd0 || fflags !== 5'h00 || out_valid !== 1'b0 ||
        in_ready !== 1'b1 || result_out !== 32'h0 ||
        status_out !== 5'h0 || tag_out !== 1'b0 || busy !== 1'b0) begin
      n_err++;
      $display("FAIL arst got cnt%0d fl%h v%b r%b %h s%h t%b b%b",
               count, fflags, out_valid, in_ready, result_out,
               status_out, tag_out, busy);
    end
    #1 rst = 1'b0;
    tick();
    n_cmp++; if (count !== 3'd0 || fflags !== 5'h00) begin n_err++;
      $display("FAIL arst_hold got cnt%0d fl%h want 0 00",
               count, fflags); end
  endtask

  initial begin
    test_reset();
    test_order();
    test_full();
    test_back_to_back();
    test_flags();
    test_flush();
    test_async_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/fpnew_result_buffer.md
# fpnew_result_buffer

Output-side buffer directly downstream of the FPU top-level's arbitrated result port. It captures each result/status/tag beat in a small in-order FIFO, decoupling the FPU's `out_ready_i` from core writeback stalls. It also maintains the sticky IEEE exception flags (fflags) by OR-ing in each retired beat's status, with a CSR-side write/clear port.

## Interface
- `Width`, 32: result width in bits; matches the FPU feature width.
- `Depth`, 4: FIFO entries; power of two, at least 2.
- `clk_i`  in  1  clock; all state on rising edge.
- `rst_i`  in  1  reset, asynchronous, active-high.
- `flush_i`  in  1  synchronous discard of all buffered entries.
- `in_valid_i`  in  1  FPU result valid (from FPU `out_valid_o`).
- `in_ready_o`  out  1  buffer can accept (to FPU `out_ready_i`).
- `result_i`  in  Width  FPU result.
- `status_i`  in  5  FPU status `{NV,DZ,OF,UF,NX}` (`fpnew_pkg::status_t`).
- `tag_i`  in  1  FPU tag.
- `out_valid_o`  out  1  head entry valid toward writeback.
- `out_ready_i`  in  1  writeback accepts head.
- `result_o`  out  Width  head result.
- `status_o`  out  5  head status.
- `tag_o`  out  1  head tag.
- `fflags_o`  out  5  sticky accumulated flags.
- `fflags_wr_i`  in  1  CSR write of fflags.
- `fflags_wdata_i`  in  5  CSR write data.
- `fflags_clr_i`  in  1  clear fflags to 0.
- `count_o`  out  $clog2(Depth+1)  occupied entries.
- `busy_o`  out  1  `count_o != 0`.

## Operation
- Push occurs when `in_valid_i && in_ready_o && !flush_i`. Pop occurs when `out_valid_o && out_ready_i && !flush_i`.
- `in_ready_o = (count != Depth)`. It does not depend on `out_ready_i`: no pass-through when full, even if a pop happens in the same cycle.
- `out_valid_o = (count != 0)`. Head fields come straight from storage. Fields are don't-care when empty, but the implementation drives 0 so the bench can check them.
- Order is strict FIFO. Read and write pointers are `$clog2(Depth)` bits and wrap modulo Depth.
- Push and pop in the same cycle: count is unchanged and both pointers advance. This holds at count=1: the new entry is written while the old head leaves.
- Flush: the next state is empty (pointers and count to 0). Any push or pop in the flush cycle is ignored, and fflags are not updated by entries discarded in that cycle.
- fflags next-state, in priority order:
  - base = `fflags_wdata_i` if `fflags_wr_i`; else 0 if `fflags_clr_i`; else the current value.
  - next = base | (pop ? `status_o` : 0).
  - So a CSR write concurrent with a retiring beat never loses that beat's exceptions, and write beats clear.
- Flags accumulate on pop (retire to writeback), not on push.

## Timing
- Reset values: `in_ready_o`=1, `out_valid_o`=0, `result_o`=0, `status_o`=0, `tag_o`=0, `fflags_o`=0, `count_o`=0, `busy_o`=0.
- Latency: a beat pushed in cycle N is visible at `out_valid_o` in N+1 (registered storage, no fall-through).
- `fflags_o` reflects a pop in cycle N from N+1. CSR write/clear also take effect at N+1.
- Asserting reset mid-operation drops all entries and flags immediately (asynchronous). Deassertion is synchronised externally.
- Max throughput is one beat per cycle in steady state while count is between 1 and Depth-1.

## Structure
- `status_t` is reused from `fpnew_pkg`. Add `FFLAGS_W = 5` to `fpnew_pkg`.
- One sub-module: `fpnew_result_fifo`, a generic Width+6-bit, Depth-entry synchronous FIFO with flush, full/empty and count.
- The top wraps the FIFO and holds the fflags accumulator register and its next-state logic.
- Elaboration check: `Depth` must be a power of two and at least 2.

## Test plan
- Reset then push 3 beats (results 0x3F800000, 0x40000000, 0x40400000; status 0; tags 0,1,0) with `out_ready_i`=0:
  - `count_o`=3 and `in_ready_o`=1.
  - Release `out_ready_i`: the three beats emerge in order on consecutive cycles, then `out_valid_o`=0.
- Fill to Depth=4 with `out_ready_i`=0:
  - `in_ready_o`=0.
  - A fifth `in_valid_i` is held off.
  - One pop plus a simultaneous valid: no push that cycle; the push is accepted the next cycle.
- Continuous push/pop for 20 beats at count=1: each result appears exactly one cycle after input, with no bubbles and no reordering across pointer wrap.
- Flags:
  - Pop a beat with status 0x01 (NX), then one with 0x10 (NV): `fflags_o`=0x11.
  - `fflags_clr_i`: `fflags_o`=0.
  - `fflags_wr_i` with wdata 0x04 in the same cycle as popping status 0x01: `fflags_o`=0x05.
- Flush with 3 entries and a concurrent push/pop:
  - Next cycle `count_o`=0, `out_valid_o`=0 and fflags unchanged.
  - A subsequent push behaves normally.
- Assert `rst_i` asynchronously mid-stream (between clock edges) with count=2 and fflags=0x1F: all outputs return to reset values before the next edge.
